// File: rtl/posit_mul_pipe.sv
// Three-stage pipelined posit<N,ES> multiplier: S1 decode, S2 multiply/normalise, S3 round/encode.
// Optional build macro POSIT_MUL_STATUS_EN adds out_status = {nar, zero, sat} alongside out_p.
module posit_mul_pipe #(
    parameter int N  = 32,
    parameter int ES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_p
`ifdef POSIT_MUL_STATUS_EN
    ,
    output logic [2:0]   out_status
`endif
);

    localparam int F    = N - ES - 2;          // fraction width including hidden bit
    localparam int SW   = $clog2(N) + ES + 2;  // operand scale width
    localparam int PSW  = SW + 2;              // product scale width
    localparam int LW   = $clog2(N) + 1;
    localparam int EW   = (ES > 0) ? ES : 1;
    localparam int TL   = ES + 2 * F - 1;
    localparam int VW   = 2 + TL + N;
    localparam int MAXS = (N - 2) << ES;       // scale of maxpos

    typedef struct packed {
        logic                 nar;
        logic                 zero;
        logic                 sgn;
        logic signed [SW-1:0] sc;
        logic [F-1:0]         fr;
    } dec_t;

    function automatic dec_t decode(input logic [N-1:0] x);
        dec_t                 d;
        logic [N-2:0]         v;
        logic [N-4:0]         t;
        logic [LW-1:0]        r;
        logic                 done;
        logic signed [SW-1:0] rs;
        logic signed [SW-1:0] k;
        logic [EW-1:0]        e;
        d      = '0;
        d.zero = (x == '0);
        d.nar  = (x == {1'b1, {(N-1){1'b0}}});
        d.sgn  = x[N-1];
        v      = x[N-1] ? (N-1)'(~x + 1'b1) : x[N-2:0];
        r      = '0;
        done   = 1'b0;
        for (int i = N - 2; i >= 0; i--) begin
            if (!done && (v[i] == v[N-2])) r = r + 1'b1;
            else done = 1'b1;
        end
        rs = SW'(r);
        k  = v[N-2] ? rs - SW'(1) : -rs;
        // Drop regime run and its terminator; anything shifted past the end reads as zero.
        t    = (N-3)'(({v, 1'b0} << (r + 1'b1)) >> 3);
        e    = (ES > 0) ? t[N-4 -: EW] : '0;
        d.sc = (k <<< ES) + SW'(e);
        d.fr = {1'b1, t[N-4-ES -: F-1]};
        return d;
    endfunction

    function automatic logic is_sat(input logic signed [PSW-1:0] sc, input logic [2*F-2:0] fr);
        return (sc > MAXS) || ((sc == MAXS) && (|fr)) || (sc < -MAXS);
    endfunction

    function automatic logic [N-1:0] encode(input logic sgn, input logic signed [PSW-1:0] sc,
                                            input logic [2*F-2:0] fr);
        logic signed [PSW-1:0] k;
        logic [LW-1:0]         sh;
        logic [TL-1:0]         tail;
        logic [VW-1:0]         base;
        logic [VW-1:0]         vv;
        logic [N-2:0]          body;
        logic                  guard;
        logic                  sticky;
        logic                  rup;
        logic [N-1:0]          mag;
        k    = sc >>> ES;
        sh   = (k >= 0) ? LW'(k) : LW'(-k - PSW'(1));
        tail = (TL'(sc[EW-1:0]) << (2 * F - 1)) | TL'(fr);
        // Arithmetic shift grows a ones-run for k>=0 and a zeros-run for k<0.
        base   = {(k >= 0) ? 2'b10 : 2'b01, tail, {N{1'b0}}};
        vv     = VW'($signed(base) >>> sh);
        body   = vv[VW-1 -: N-1];
        guard  = vv[VW-N];
        sticky = |vv[VW-N-1:0];
        rup    = guard && (sticky || body[0]);
        mag    = {1'b0, body} + N'(rup);
        if ((sc > MAXS) || ((sc == MAXS) && (|fr))) mag = {1'b0, {(N-1){1'b1}}};
        else if (sc < -MAXS) mag = N'(1);
        return sgn ? (~mag + 1'b1) : mag;
    endfunction

    logic                  alive, v1, v2, v3;
    logic                  nar1, zero1, sgn1;
    logic signed [SW-1:0]  sa1, sb1;
    logic [F-1:0]          fa1, fb1;
    logic                  nar2, zero2, sgn2;
    logic signed [PSW-1:0] sc2;
    logic [2*F-2:0]        fr2;
    logic                  en1, en2, en3, acc;
    dec_t                  dec_a, dec_b;
    logic [2*F-1:0]        prod;
    logic [2*F-2:0]        fr_n;
    logic signed [PSW-1:0] sc_n;
    logic [N-1:0]          p_n;

    // Valid/ready: a word moves when valid && ready at a rising edge; valid and data hold until then.
    // Each stage loads when it is empty or its content moves on in the same cycle.
    always_comb begin
        en3      = !v3 || out_ready;
        en2      = !v2 || en3;
        en1      = !v1 || en2;
        in_ready = alive && en1;
        acc      = in_valid && in_ready;
        dec_a    = decode(in_a);
        dec_b    = decode(in_b);
        prod     = (2*F)'(fa1) * (2*F)'(fb1);
        fr_n     = prod[2*F-1] ? prod[2*F-2:0] : {prod[2*F-3:0], 1'b0};
        sc_n     = PSW'(sa1) + PSW'(sb1) + PSW'(prod[2*F-1]);
        if (nar2) p_n = {1'b1, {(N-1){1'b0}}};
        else if (zero2) p_n = '0;
        else p_n = encode(sgn2, sc2, fr2);
    end

    assign out_valid = v3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alive <= 1'b0;
            v1    <= 1'b0;
            v2    <= 1'b0;
            v3    <= 1'b0;
            nar1  <= 1'b0;
            zero1 <= 1'b0;
            sgn1  <= 1'b0;
            sa1   <= '0;
            sb1   <= '0;
            fa1   <= '0;
            fb1   <= '0;
            nar2  <= 1'b0;
            zero2 <= 1'b0;
            sgn2  <= 1'b0;
            sc2   <= '0;
            fr2   <= '0;
            out_p <= '0;
        end else begin
            alive <= 1'b1;
            if (en1) v1 <= acc;
            if (acc) begin
                nar1  <= dec_a.nar || dec_b.nar;
                zero1 <= !(dec_a.nar || dec_b.nar) && (dec_a.zero || dec_b.zero);
                sgn1  <= dec_a.sgn ^ dec_b.sgn;
                sa1   <= dec_a.sc;
                sb1   <= dec_b.sc;
                fa1   <= dec_a.fr;
                fb1   <= dec_b.fr;
            end
            if (en2) v2 <= v1;
            if (en2 && v1) begin
                nar2  <= nar1;
                zero2 <= zero1;
                sgn2  <= sgn1;
                sc2   <= sc_n;
                fr2   <= fr_n;
            end
            if (en3) v3 <= v2;
            if (en3 && v2) out_p <= p_n;
        end
    end

`ifdef POSIT_MUL_STATUS_EN
    logic [2:0] st_n;
    always_comb st_n = {nar2, !nar2 && zero2, !nar2 && !zero2 && is_sat(sc2, fr2)};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) out_status <= '0;
        else if (en3 && v2) out_status <= st_n;
    end
`endif

endmodule

// File: tb/tb_posit_mul_pipe.sv
// Scoreboard bench for posit_mul_pipe (N=32, ES=2): directed vectors, backpressure and async reset.
module tb_posit_mul_pipe;

  localparam int N = 32;
  localparam int ES = 2;

  logic clk, rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [N-1:0] in_a, in_b, out_p;
`ifdef POSIT_MUL_STATUS_EN
  logic [2:0] out_status;
`endif

  posit_mul_pipe #(.N(N), .ES(ES)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_a(in_a),
    .in_b(in_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_p(out_p)
`ifdef POSIT_MUL_STATUS_EN
    ,
    .out_status(out_status)
`endif
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // hand-computed vectors: a, b, product, status {nar, zero, sat}
  typedef struct packed {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] p;
    logic [2:0]   st;
  } vec_t;

  vec_t vecs [17] = '{
    '{32'h40000000, 32'h48000000, 32'h48000000, 3'b000},  // 1 * 2
    '{32'h44000000, 32'h44000000, 32'h49000000, 3'b000},  // 1.5 * 1.5
    '{32'hC0000000, 32'h50000000, 32'hB0000000, 3'b000},  // -1 * 4
    '{32'h80000000, 32'h00000000, 32'h80000000, 3'b100},  // NaR * 0
    '{32'h00000000, 32'h7FFFFFFF, 32'h00000000, 3'b010},  // 0 * maxpos
    '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 3'b001},  // maxpos^2 saturates
    '{32'h00000001, 32'h00000001, 32'h00000001, 3'b001},  // minpos^2 saturates
    '{32'h80000001, 32'h7FFFFFFF, 32'h80000001, 3'b001},  // -maxpos * maxpos
    '{32'h00000001, 32'h50000000, 32'h00000002, 3'b000},  // minpos*4: tie -> even
    '{32'h00000001, 32'h48000000, 32'h00000001, 3'b000},  // minpos*2: round down
    '{32'h00000001, 32'h58000000, 32'h00000002, 3'b000},  // minpos*8: round up
    '{32'h7FFFFFFF, 32'h38000000, 32'h7FFFFFFF, 3'b000},  // maxpos*0.5 rounds to maxpos
    '{32'h44000000, 32'h40000001, 32'h44000002, 3'b000},  // fraction tie, odd lsb
    '{32'hBC000000, 32'h44000000, 32'hB7000000, 3'b000},  // -1.5 * 1.5
    '{32'h80000000, 32'h40000000, 32'h80000000, 3'b100},  // NaR * 1
    '{32'h40000000, 32'h40000000, 32'h40000000, 3'b000},  // 1 * 1
    '{32'h48000000, 32'h48000000, 32'h50000000, 3'b000}   // 2 * 2
  };

  // scoreboard
  logic [N-1:0] exp_q[$];
  logic [2:0]   st_q[$];
  int           acc_q[$];
  bit           lat_q[$];
  int checks = 0;
  int failures = 0;
  int n_acc = 0;

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%h required=0x%h", name, act, req);
    end
  endtask

  logic [N-1:0] m_exp;
  logic [2:0]   m_st;
  int           m_acc;
  bit           m_lat;

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output actual=0x%h required=none", out_p);
      end else begin
        m_exp = exp_q.pop_front();
        m_st  = st_q.pop_front();
        m_acc = acc_q.pop_front();
        m_lat = lat_q.pop_front();
        check("out_p", out_p, m_exp);
        if (m_lat) check("latency", N'(cyc - m_acc), N'(3));
`ifdef POSIT_MUL_STATUS_EN
        check("out_status", N'(out_status), N'(m_st));
`endif
      end
    end
  end

  // driver tasks; callers sit just after a rising edge
  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int idx, input bit lat);
    logic rdy;
    bit done;
    done = 1'b0;
    in_valid = 1'b1;
    in_a = vecs[idx].a;
    in_b = vecs[idx].b;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        exp_q.push_back(vecs[idx].p);
        st_q.push_back(vecs[idx].st);
        acc_q.push_back(cyc - 1);
        lat_q.push_back(lat);
        n_acc++;
        done = 1'b1;
      end
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout vector=%0d actual=not_accepted required=accepted", idx);
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain_empty", N'(exp_q.size()), N'(0));
    sync();
  endtask

  int bp_idx [5] = '{15, 16, 0, 1, 2};
  int base;
  int stale;

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_out_valid", N'(out_valid), N'(0));
    check("reset_in_ready", N'(in_ready), N'(0));
    check("reset_out_p", out_p, N'(0));
`ifdef POSIT_MUL_STATUS_EN
    check("reset_status", N'(out_status), N'(0));
`endif
    sync();
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("ready_after_reset", N'(in_ready), N'(1));
    sync();
    out_ready = 1'b1;

    // single op, then a back-to-back pair, then the rest streamed
    send(0, 1'b1);
    idle();
    drain();
    send(1, 1'b1);
    send(2, 1'b1);
    idle();
    drain();
    for (int i = 3; i <= 14; i++) send(i, 1'b1);
    idle();
    drain();

    // backpressure: only three fit while the output is stalled
    out_ready = 1'b0;
    base = n_acc;
    fork
      begin
        for (int i = 0; i < 5; i++) send(bp_idx[i], 1'b0);
        idle();
      end
      begin
        repeat (10) @(negedge clk);
        check("bp_accepted", N'(n_acc - base), N'(3));
        check("bp_in_ready", N'(in_ready), N'(0));
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          check("bp_out_valid", N'(out_valid), N'(1));
          check("bp_hold", out_p, vecs[15].p);
        end
        sync();
        out_ready = 1'b1;
      end
    join
    drain();
    check("bp_total_accepted", N'(n_acc - base), N'(5));

    // asynchronous reset with two results in flight
    out_ready = 1'b0;
    send(1, 1'b0);
    send(2, 1'b0);
    idle();
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
    check("rst_pre_valid", N'(out_valid), N'(1));
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_valid", N'(out_valid), N'(0));
    check("rst_async_ready", N'(in_ready), N'(0));
    check("rst_async_out_p", out_p, N'(0));
    exp_q.delete();
    st_q.delete();
    acc_q.delete();
    lat_q.delete();
    repeat (2) @(negedge clk);
    sync();
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_release_ready", N'(in_ready), N'(1));
    stale = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("rst_no_stale", N'(stale), N'(0));
    sync();
    send(5, 1'b1);
    idle();
    drain();

    check("final_queue_empty", N'(exp_q.size()), N'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
